// File: rtl/s1_bit_serializer_if.sv
// Parallel-in / serial-out bundle between a word producer and the S1 bit serializer.
// The master drives words in; the slave returns handshake and the serial stream.
interface s1_bit_serializer_if #(
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x1;
    logic             x1_valid;
    logic             frame_start;
    logic [IW-1:0]    bit_idx;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  x1,
        input  x1_valid,
        input  frame_start,
        input  bit_idx
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output x1,
        output x1_valid,
        output frame_start,
        output bit_idx
    );
endinterface

// File: rtl/s1_bit_serializer.sv
// Double-buffered word-to-bit serializer feeding the S1 state machine's x1 input.
// One word shifts while a second waits in hold, so consecutive words stream without a gap.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | nothing shifting; x1 parked at IDLE_LEVEL, x1_valid low
//   ST_SHIFT | a word is on x1, bit_idx walks 0..WIDTH-1
module s1_bit_serializer #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    s1_bit_serializer_if.slave   bus
);
    localparam int            IW       = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shifter_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic [IW-1:0]    bit_idx_q;
    logic             x1_q;
    logic             x1_valid_q;
    logic             frame_start_q;

    logic             transfer;
    logic             shifter_free;
    logic [WIDTH-1:0] shifter_d;

    // The shifter always presents its current bit at the output end.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign transfer     = bus.din_valid & ~hold_full_q;
    assign shifter_free = (state_q == ST_IDLE) || (bit_idx_q == LAST_IDX);
    assign shifter_d    = advance(shifter_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            shifter_q     <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            bit_idx_q     <= '0;
            x1_q          <= IDLE_LEVEL;
            x1_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (shifter_free) begin
            // A held word always wins over a new offer; an offer cannot be taken
            // in the same cycle because din_ready is low while hold is full.
            if (hold_full_q) begin
                state_q       <= ST_SHIFT;
                shifter_q     <= hold_q;
                hold_full_q   <= 1'b0;
                bit_idx_q     <= '0;
                x1_q          <= first_bit(hold_q);
                x1_valid_q    <= 1'b1;
                frame_start_q <= 1'b1;
            end else if (transfer) begin
                state_q       <= ST_SHIFT;
                shifter_q     <= bus.din;
                bit_idx_q     <= '0;
                x1_q          <= first_bit(bus.din);
                x1_valid_q    <= 1'b1;
                frame_start_q <= 1'b1;
            end else begin
                state_q       <= ST_IDLE;
                bit_idx_q     <= '0;
                x1_q          <= IDLE_LEVEL;
                x1_valid_q    <= 1'b0;
                frame_start_q <= 1'b0;
            end
        end else begin
            state_q       <= ST_SHIFT;
            shifter_q     <= shifter_d;
            bit_idx_q     <= bit_idx_q + IW'(1);
            x1_q          <= first_bit(shifter_d);
            x1_valid_q    <= 1'b1;
            frame_start_q <= 1'b0;
            if (transfer) begin
                hold_q      <= bus.din;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign bus.din_ready   = ~hold_full_q;
    assign bus.x1          = x1_q;
    assign bus.x1_valid    = x1_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.bit_idx     = bit_idx_q;
endmodule
